rotl_iter: RTL and testbench

ROTL_ITER -- requirements
Module: rotl_iter

---
 rtl/rotl_iter.sv | 117 +++++++++++
 tb/tb_rotl_iter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rotl_iter.sv
// rotl_iter: iterative shift/rotate-left unit.
// Each accepted request walks the shift amount one bit per clock, LSB first.
// Stage k applies a shift of 2^k when amount bit k is set. The result appears
// a fixed SHIFT_W cycles after acceptance, whatever the shift amount.
// Reset is synchronous and active high.
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   rst        synchronous active-high reset
//   in_valid   request valid
//   in_ready   request can be accepted (IDLE and not in reset)
//   a          operand
//   shift_mag  left-shift amount, 0..DATA_WIDTH-1
//   rotate     1 = rotate left, 0 = logical shift left with zero fill
//   out_valid  out holds a completed result
//   out_ready  consumer accepts the result
//   out        result, held between operations
module rotl_iter #(
  parameter int DATA_WIDTH = 1024,
  localparam int SHIFT_W   = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [SHIFT_W-1:0]    shift_mag,
  input  logic                  rotate,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int                 LAST_INT   = SHIFT_W - 1;
  localparam logic [SHIFT_W-1:0] LAST_STAGE = LAST_INT[SHIFT_W-1:0];

  logic [1:0]            state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic [SHIFT_W-1:0]    amt_q;
  logic                  mode_q;
  logic [SHIFT_W-1:0]    stage_q;
  logic                  out_valid_q;

  logic [SHIFT_W-1:0]      step_amt;
  logic [2*DATA_WIDTH-1:0] dbl_shift;
  logic [DATA_WIDTH-1:0]   data_next;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out       = out_q;

  // Stage k shifts by 2^k. Rotation uses the upper half of the doubled operand,
  // so bits leaving the MSB wrap around into the LSBs.
  always_comb begin
    step_amt           = '0;
    step_amt[stage_q]  = 1'b1;
    dbl_shift          = {data_q, data_q} << step_amt;
    data_next          = data_q;
    if (amt_q[stage_q]) begin
      if (mode_q) begin
        data_next = dbl_shift[2*DATA_WIDTH-1:DATA_WIDTH];
      end else begin
        data_next = data_q << step_amt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      out_q       <= '0;
      amt_q       <= '0;
      mode_q      <= 1'b0;
      stage_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= a;
            amt_q   <= shift_mag;
            mode_q  <= rotate;
            stage_q <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          data_q  <= data_next;
          // The counter can hold SHIFT_W, so the increment past the last stage never wraps.
          stage_q <= stage_q + 1'b1;
          if (stage_q == LAST_STAGE) begin
            out_q       <= data_next;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotl_iter.sv
// Directed-vector bench for rotl_iter at DATA_WIDTH=8.
module tb_rotl_iter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [2:0] shift_mag;
  logic       rotate;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;

  int n_cmp = 0;
  int n_bad = 0;
  int rises = 0;
  int r0;
  logic ov_d = 1'b0;

  rotl_iter #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shift_mag (shift_mag),
    .rotate    (rotate),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && !ov_d) rises <= rises + 1;
    ov_d <= out_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic accept(input logic [7:0] av, input logic [2:0] n, input logic r, input string tag);
    check({tag, " in_ready"}, in_ready, 1);
    a = av; shift_mag = n; rotate = r; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " busy in_ready"}, in_ready, 0);
    check({tag, " busy out_valid"}, out_valid, 0);
  endtask

  // out_valid must rise exactly three edges after the accepting edge.
  task automatic expect_result(input logic [7:0] exp, input string tag);
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      check($sformatf("%s latency e%0d", tag, e), out_valid, (e == 3) ? 1 : 0);
    end
    check({tag, " out"}, out, exp);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " post out_valid"}, out_valid, 0);
    check({tag, " post in_ready"}, in_ready, 1);
  endtask

  task automatic run_op(input logic [7:0] av, input logic [2:0] n, input logic r,
                        input logic [7:0] exp, input string tag);
    accept(av, n, r, tag);
    expect_result(exp, tag);
    handshake(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; shift_mag = '0; rotate = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out", out, 0);
    rst = 1'b0;
    #1;

    // First request taken in the first cycle after reset release.
    run_op(8'h81, 3'd1, 1'b1, 8'h03, "rot81n1");
    run_op(8'h81, 3'd1, 1'b0, 8'h02, "lsh81n1");
    run_op(8'h01, 3'd7, 1'b1, 8'h80, "rot01n7");
    run_op(8'hFF, 3'd7, 1'b0, 8'h80, "lshFFn7");
    run_op(8'hA5, 3'd0, 1'b1, 8'hA5, "rotA5n0");
    run_op(8'hA5, 3'd0, 1'b0, 8'hA5, "lshA5n0");
    run_op(8'h96, 3'd3, 1'b1, 8'hB4, "rot96n3");
    run_op(8'h96, 3'd3, 1'b0, 8'hB0, "lsh96n3");
    run_op(8'h96, 3'd4, 1'b1, 8'h69, "rot96n4");

    // Backpressure with a competing request held on in_valid.
    accept(8'hC3, 3'd2, 1'b1, "bp");
    expect_result(8'h0F, "bp");
    a = 8'h55; shift_mag = 3'd1; rotate = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp hold out_valid %0d", i), out_valid, 1);
      check($sformatf("bp hold out %0d", i), out, 8'h0F);
      check($sformatf("bp hold in_ready %0d", i), in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release out_valid", out_valid, 0);
    check("bp no same-cycle accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp next accepted", in_ready, 0);
    expect_result(8'hAA, "bp2");
    handshake("bp2");

    // Input isolation: inputs change and in_valid/out_ready pulse while busy.
    r0 = rises;
    accept(8'h3C, 3'd2, 1'b0, "iso");
    a = 8'hFF; shift_mag = 3'd5; rotate = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("iso e1 out_valid", out_valid, 0);
    @(negedge clk);
    check("iso e2 out_valid", out_valid, 0);
    @(negedge clk);
    check("iso e3 out_valid", out_valid, 1);
    check("iso out", out, 8'hF0);
    handshake("iso");
    repeat (4) @(negedge clk);
    check("iso episodes", rises - r0, 1);

    // Reset abort on the second BUSY cycle.
    accept(8'h81, 3'd1, 1'b1, "abort");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    r0 = rises;
    check("abort out_valid", out_valid, 0);
    check("abort out", out, 0);
    check("abort in_ready", in_ready, 1);
    repeat (5) @(negedge clk);
    check("abort no episode", rises - r0, 0);
    run_op(8'h81, 3'd1, 1'b1, 8'h03, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
